// File: rtl/rab_slice_cfg_seq_pkg.sv
// Types and constants shared by the RAB slice configuration sequencer.
// Defining RAB_SLICE_CFG_VERIFY_EN adds the flags read-back states to the FSM.
package rab_slice_cfg_seq_pkg;

  localparam int LITE_AW = 32;
  localparam int LITE_DW = 32;

  localparam logic [31:0] RAB_CFG_BASE     = 32'hA800_0000;
  localparam logic [31:0] RAB_PORT_STRIDE  = 32'h0000_1000;
  localparam logic [31:0] RAB_SLICE_STRIDE = 32'h0000_0020;

  // Flags sit in the last slice register so a partial sequence never enables a slice.
  localparam logic [4:0] SLICE_OFS_FLAGS = 5'h18;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    CFG_OK     = 2'd0,
    CFG_BRESP  = 2'd1,
    CFG_RANGE  = 2'd2,
    CFG_VERIFY = 2'd3
  } rab_cfg_status_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WR_AW_W,
    ST_WR_B,
`ifdef RAB_SLICE_CFG_VERIFY_EN
    ST_VERIFY_AR,
    ST_VERIFY_R,
`endif
    ST_DONE
  } seq_state_e;

  typedef struct packed {
    logic [LITE_AW-1:0]   aw_addr;
    logic [2:0]           aw_prot;
    logic                 aw_valid;
    logic [LITE_DW-1:0]   w_data;
    logic [LITE_DW/8-1:0] w_strb;
    logic                 w_valid;
    logic                 b_ready;
    logic [LITE_AW-1:0]   ar_addr;
    logic [2:0]           ar_prot;
    logic                 ar_valid;
    logic                 r_ready;
  } lite_cfg_req_t;

  typedef struct packed {
    logic               aw_ready;
    logic               w_ready;
    logic [1:0]         b_resp;
    logic               b_valid;
    logic               ar_ready;
    logic [LITE_DW-1:0] r_data;
    logic [1:0]         r_resp;
    logic               r_valid;
  } lite_cfg_resp_t;

  // Word k of a slice lives at byte offset 4*k (0x00..0x18).
  function automatic logic [4:0] slice_reg_ofs(input logic [2:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/rab_slice_cfg_seq.sv
// Programs one RAB TLB slice per descriptor as an ordered series of AXI-Lite single-beat writes.
// Optional flags read-back check is enabled with RAB_SLICE_CFG_VERIFY_EN.
module rab_slice_cfg_seq
  import rab_slice_cfg_seq_pkg::*;
#(
  parameter int          AxiAw       = 64,
  parameter int          LiteAw      = LITE_AW,
  parameter int          LiteDw      = LITE_DW,
  parameter int          NumSlices   = 32,
  parameter logic [31:0] CfgBase     = RAB_CFG_BASE,
  parameter logic [31:0] PortStride  = RAB_PORT_STRIDE,
  parameter logic [31:0] SliceStride = RAB_SLICE_STRIDE,
  parameter type         lite_req_t  = lite_cfg_req_t,
  parameter type         lite_resp_t = lite_cfg_resp_t,
  localparam int         SliceIdxW   = $clog2(NumSlices)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_port_i,
  input  logic [SliceIdxW-1:0] req_idx_i,
  input  logic [AxiAw-1:0]     req_first_i,
  input  logic [AxiAw-1:0]     req_last_i,
  input  logic [AxiAw-1:0]     req_base_i,
  input  logic [2:0]           req_flags_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           status_o,
  output logic [2:0]           err_wr_idx_o,
  output lite_req_t            cfg_req_o,
  input  lite_resp_t           cfg_resp_i
);

  // Narrow lite bus: lo/hi halves of every address field. Wide bus: even words only.
  localparam bit         SplitWords = (LiteDw < AxiAw);
  localparam logic [2:0] WordStep   = SplitWords ? 3'd1 : 3'd2;
  localparam logic [2:0] LastWord   = SLICE_OFS_FLAGS[4:2];

  seq_state_e          state_reg;
  rab_cfg_status_e     status_reg;
  logic [2:0]          err_idx_reg;
  logic [2:0]          word_reg;
  logic                ready_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                aw_valid_reg;
  logic                w_valid_reg;
  logic                b_ready_reg;
  logic [AxiAw-1:0]    first_reg;
  logic [AxiAw-1:0]    last_reg;
  logic [AxiAw-1:0]    base_reg;
  logic [2:0]          flags_reg;
  logic [LiteAw-1:0]   slice_addr_reg;
  logic [LiteDw-1:0]   wr_data;
  logic [LiteAw-1:0]   wr_addr;
  logic                aw_hs;
  logic                w_hs;
  logic                ar_valid;
  logic                r_ready;
  logic                unused_resp;

  assign aw_hs       = aw_valid_reg & cfg_resp_i.aw_ready;
  assign w_hs        = w_valid_reg & cfg_resp_i.w_ready;
  assign wr_addr     = slice_addr_reg + LiteAw'(slice_reg_ofs(word_reg));
  assign unused_resp = ^cfg_resp_i;

  always_comb begin
    wr_data = '0;
    unique case (word_reg)
      3'd0:    wr_data = LiteDw'(first_reg);
      3'd1:    wr_data = LiteDw'(first_reg >> LiteDw);
      3'd2:    wr_data = LiteDw'(last_reg);
      3'd3:    wr_data = LiteDw'(last_reg >> LiteDw);
      3'd4:    wr_data = LiteDw'(base_reg);
      3'd5:    wr_data = LiteDw'(base_reg >> LiteDw);
      default: wr_data = LiteDw'(flags_reg);
    endcase
  end

`ifdef RAB_SLICE_CFG_VERIFY_EN
  logic ar_valid_reg;
  logic r_ready_reg;
  assign ar_valid = ar_valid_reg;
  assign r_ready  = r_ready_reg;
`else
  assign ar_valid = 1'b0;
  assign r_ready  = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      status_reg     <= CFG_OK;
      err_idx_reg    <= '0;
      word_reg       <= '0;
      ready_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      aw_valid_reg   <= 1'b0;
      w_valid_reg    <= 1'b0;
      b_ready_reg    <= 1'b0;
      first_reg      <= '0;
      last_reg       <= '0;
      base_reg       <= '0;
      flags_reg      <= '0;
      slice_addr_reg <= '0;
`ifdef RAB_SLICE_CFG_VERIFY_EN
      ar_valid_reg   <= 1'b0;
      r_ready_reg    <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (req_valid_i && ready_reg) begin
            ready_reg      <= 1'b0;
            busy_reg       <= 1'b1;
            first_reg      <= req_first_i;
            last_reg       <= req_last_i;
            base_reg       <= req_base_i;
            flags_reg      <= req_flags_i;
            slice_addr_reg <= LiteAw'(CfgBase)
                              + (req_port_i ? LiteAw'(PortStride) : '0)
                              + LiteAw'(req_idx_i) * LiteAw'(SliceStride);
            state_reg      <= ST_CHECK;
          end else begin
            ready_reg <= 1'b1;
          end
        end
        ST_CHECK: begin
          word_reg <= '0;
          if (first_reg > last_reg) begin
            state_reg   <= ST_DONE;
            done_reg    <= 1'b1;
            status_reg  <= CFG_RANGE;
            err_idx_reg <= '0;
          end else begin
            aw_valid_reg <= 1'b1;
            w_valid_reg  <= 1'b1;
            state_reg    <= ST_WR_AW_W;
          end
        end
        ST_WR_AW_W: begin
          // AW and W complete independently; move on once neither is outstanding.
          if (aw_hs) aw_valid_reg <= 1'b0;
          if (w_hs)  w_valid_reg  <= 1'b0;
          if ((aw_hs || !aw_valid_reg) && (w_hs || !w_valid_reg)) begin
            b_ready_reg <= 1'b1;
            state_reg   <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (cfg_resp_i.b_valid) begin
            b_ready_reg <= 1'b0;
            if (cfg_resp_i.b_resp != AXI_RESP_OKAY) begin
              state_reg   <= ST_DONE;
              done_reg    <= 1'b1;
              status_reg  <= CFG_BRESP;
              err_idx_reg <= word_reg;
            end else if (word_reg == LastWord) begin
`ifdef RAB_SLICE_CFG_VERIFY_EN
              ar_valid_reg <= 1'b1;
              state_reg    <= ST_VERIFY_AR;
`else
              state_reg   <= ST_DONE;
              done_reg    <= 1'b1;
              status_reg  <= CFG_OK;
              err_idx_reg <= '0;
`endif
            end else begin
              word_reg     <= word_reg + WordStep;
              aw_valid_reg <= 1'b1;
              w_valid_reg  <= 1'b1;
              state_reg    <= ST_WR_AW_W;
            end
          end
        end
`ifdef RAB_SLICE_CFG_VERIFY_EN
        ST_VERIFY_AR: begin
          if (cfg_resp_i.ar_ready) begin
            ar_valid_reg <= 1'b0;
            r_ready_reg  <= 1'b1;
            state_reg    <= ST_VERIFY_R;
          end
        end
        ST_VERIFY_R: begin
          if (cfg_resp_i.r_valid) begin
            r_ready_reg <= 1'b0;
            state_reg   <= ST_DONE;
            done_reg    <= 1'b1;
            if (cfg_resp_i.r_resp != AXI_RESP_OKAY || cfg_resp_i.r_data[2:0] != flags_reg) begin
              status_reg  <= CFG_VERIFY;
              err_idx_reg <= LastWord;
            end else begin
              status_reg  <= CFG_OK;
              err_idx_reg <= '0;
            end
          end
        end
`endif
        ST_DONE: begin
          busy_reg  <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_req_o          = '0;
    cfg_req_o.aw_addr  = wr_addr;
    cfg_req_o.aw_valid = aw_valid_reg;
    cfg_req_o.w_data   = wr_data;
    cfg_req_o.w_strb   = '1;
    cfg_req_o.w_valid  = w_valid_reg;
    cfg_req_o.b_ready  = b_ready_reg;
    cfg_req_o.ar_addr  = slice_addr_reg + LiteAw'(SLICE_OFS_FLAGS);
    cfg_req_o.ar_valid = ar_valid;
    cfg_req_o.r_ready  = r_ready;
  end

  assign req_ready_o  = ready_reg;
  assign busy_o       = busy_reg;
  assign done_o       = done_reg;
  assign status_o     = status_reg;
  assign err_wr_idx_o = err_idx_reg;

endmodule

// File: tb/tb_rab_slice_cfg_seq.sv
// Directed bench for rab_slice_cfg_seq with a small AXI-Lite slave model (stalls, SLVERR, read-back).
// Build with RAB_SLICE_CFG_VERIFY_EN to also cover the flags read-back stage.
`timescale 1ns/1ps
module tb_rab_slice_cfg_seq;
  import rab_slice_cfg_seq_pkg::*;

`ifdef RAB_SLICE_CFG_VERIFY_EN
  localparam int VX = 2;
  localparam int NV = 6;
`else
  localparam int VX = 0;
  localparam int NV = 5;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_port;
  logic [4:0]  req_idx;
  logic [63:0] req_first, req_last, req_base;
  logic [2:0]  req_flags;
  logic        busy, done;
  logic [1:0]  status;
  logic [2:0]  err_idx;
  lite_cfg_req_t  cfg_req;
  lite_cfg_resp_t cfg_resp;

  rab_slice_cfg_seq dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_port_i(req_port), .req_idx_i(req_idx),
    .req_first_i(req_first), .req_last_i(req_last), .req_base_i(req_base),
    .req_flags_i(req_flags),
    .busy_o(busy), .done_o(done), .status_o(status), .err_wr_idx_o(err_idx),
    .cfg_req_o(cfg_req), .cfg_resp_i(cfg_resp)
  );

  // ---------------- slave model ----------------
  int stall_aw = 0, stall_w_max = 0, err_at = -1, vec_base = 0;
  bit rd_bad = 1'b0;
  int aw_cnt, w_cnt, w_target, log_n = 0;
  logic aw_have, w_have, b_valid_q, r_valid_q;
  logic [1:0]  b_resp_q;
  logic [31:0] aw_addr_q, w_data_q, r_data_q, last_w_data;
  logic [31:0] log_addr [0:255];
  logic [31:0] log_data [0:255];
  logic aw_hs, w_hs, aw_fin, w_fin;

  always_comb begin
    cfg_resp          = '0;
    cfg_resp.aw_ready = (aw_cnt >= stall_aw) && !aw_have;
    cfg_resp.w_ready  = (w_cnt >= w_target) && !w_have;
    cfg_resp.b_valid  = b_valid_q;
    cfg_resp.b_resp   = b_resp_q;
    cfg_resp.ar_ready = 1'b1;
    cfg_resp.r_valid  = r_valid_q;
    cfg_resp.r_data   = r_data_q;
    cfg_resp.r_resp   = AXI_RESP_OKAY;
  end

  assign aw_hs  = cfg_req.aw_valid && cfg_resp.aw_ready;
  assign w_hs   = cfg_req.w_valid && cfg_resp.w_ready;
  assign aw_fin = aw_have || aw_hs;
  assign w_fin  = w_have || w_hs;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; w_target <= 0;
      aw_have <= 1'b0; w_have <= 1'b0; b_valid_q <= 1'b0; r_valid_q <= 1'b0;
      b_resp_q <= 2'b00; r_data_q <= '0;
    end else begin
      if (!cfg_req.aw_valid || aw_hs) aw_cnt <= 0; else aw_cnt <= aw_cnt + 1;
      if (!cfg_req.w_valid) begin
        w_cnt <= 0; w_target <= int'($urandom_range(0, stall_w_max));
      end else if (w_hs) w_cnt <= 0;
      else w_cnt <= w_cnt + 1;
      if (aw_fin && w_fin) begin
        log_addr[log_n] <= aw_have ? aw_addr_q : cfg_req.aw_addr;
        log_data[log_n] <= w_have ? w_data_q : cfg_req.w_data;
        last_w_data     <= w_have ? w_data_q : cfg_req.w_data;
        b_resp_q        <= ((log_n - vec_base) == err_at) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        log_n     <= log_n + 1;
        b_valid_q <= 1'b1;
        aw_have   <= 1'b0;
        w_have    <= 1'b0;
      end else begin
        if (aw_hs) begin aw_have <= 1'b1; aw_addr_q <= cfg_req.aw_addr; end
        if (w_hs)  begin w_have  <= 1'b1; w_data_q  <= cfg_req.w_data;  end
      end
      if (b_valid_q && cfg_req.b_ready) b_valid_q <= 1'b0;
      if (cfg_req.ar_valid && cfg_resp.ar_ready) begin
        r_valid_q <= 1'b1;
        r_data_q  <= rd_bad ? 32'd3 : last_w_data;
      end else if (r_valid_q && cfg_req.r_ready) r_valid_q <= 1'b0;
    end
  end

  // Handshake-hold monitor and done pulse counter.
  int proto_err = 0, done_cnt = 0;
  logic aw_pend, w_pend;
  logic [31:0] aw_pend_addr, w_pend_data;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_pend <= 1'b0; w_pend <= 1'b0;
    end else begin
      if ((aw_pend && (!cfg_req.aw_valid || cfg_req.aw_addr != aw_pend_addr)) ||
          (w_pend && (!cfg_req.w_valid || cfg_req.w_data != w_pend_data)))
        proto_err <= proto_err + 1;
      aw_pend      <= cfg_req.aw_valid && !cfg_resp.aw_ready;
      w_pend       <= cfg_req.w_valid && !cfg_resp.w_ready;
      aw_pend_addr <= cfg_req.aw_addr;
      w_pend_data  <= cfg_req.w_data;
      done_cnt     <= done_cnt + int'(done);
    end
  end

  // ---------------- checking ----------------
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic            port;
    logic [4:0]      idx;
    logic [63:0]     first, last, base;
    logic [2:0]      flags;
    int              aw_stall, w_stall, err_at;
    bit              rd_bad;
    logic [31:0]     exp_addr;
    logic [6:0][31:0] exp_data;
    int              exp_nwr;
    logic [1:0]      exp_status;
    logic [2:0]      exp_idx;
    int              exp_cycles;
  } vec_t;

  vec_t vecs [NV];

  function automatic logic [6:0][31:0] pack7(input logic [31:0] d0, d1, d2, d3, d4, d5, d6);
    return {d6, d5, d4, d3, d2, d1, d0};
  endfunction

  function automatic vec_t mk(input logic port, input logic [4:0] idx,
                              input logic [63:0] first, last, base, input logic [2:0] flags,
                              input int aw_st, w_st, e_at, input bit rb,
                              input logic [31:0] addr, input logic [6:0][31:0] data,
                              input int nwr, input logic [1:0] st, input logic [2:0] ei, input int cyc);
    vec_t v;
    v.port = port; v.idx = idx; v.first = first; v.last = last; v.base = base; v.flags = flags;
    v.aw_stall = aw_st; v.w_stall = w_st; v.err_at = e_at; v.rd_bad = rb;
    v.exp_addr = addr; v.exp_data = data; v.exp_nwr = nwr;
    v.exp_status = st; v.exp_idx = ei; v.exp_cycles = cyc;
    return v;
  endfunction

  task automatic run_vec(input int n, input vec_t v);
    int base_n, cycles;
    string p;
    p = $sformatf("v%0d", n);
    stall_aw = v.aw_stall; stall_w_max = v.w_stall; err_at = v.err_at; rd_bad = v.rd_bad;
    base_n = log_n; vec_base = log_n;
    for (int t = 0; t < 20 && !req_ready; t++) begin @(posedge clk); #1; end
    chk({p, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_port = v.port; req_idx = v.idx;
    req_first = v.first; req_last = v.last; req_base = v.base; req_flags = v.flags;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cycles = 1;
    chk({p, "_busy"}, busy, 1'b1);
    while (!done && cycles < 400) begin @(posedge clk); #1; cycles++; end
    chk({p, "_done_seen"}, done, 1'b1);
    chk({p, "_status"}, status, v.exp_status);
    chk({p, "_err_idx"}, err_idx, v.exp_idx);
    if (v.exp_cycles != 0) chk({p, "_latency"}, cycles, v.exp_cycles);
    chk({p, "_nwrites"}, log_n - base_n, v.exp_nwr);
    for (int k = 0; k < v.exp_nwr && k < log_n - base_n; k++) begin
      chk($sformatf("%s_w%0d_addr", p, k), log_addr[base_n + k], v.exp_addr + 32'(4 * k));
      chk($sformatf("%s_w%0d_data", p, k), log_data[base_n + k], v.exp_data[k]);
    end
    chk({p, "_handshake_hold"}, proto_err, 0);
    $display("%s port=%0d idx=%0d status=%0d err_idx=%0d writes=%0d cycles=%0d",
             p, v.port, v.idx, status, err_idx, log_n - base_n, cycles);
    @(posedge clk); #1;
    chk({p, "_done_pulse"}, done, 1'b0);
    chk({p, "_busy_after"}, busy, 1'b0);
    chk({p, "_status_held"}, status, v.exp_status);
  endtask

  initial begin
    int base_n;
    vecs[0] = mk(1'b1, 5'd0, 64'h1, 64'h000F_FFFF_FFFF_FFFF, 64'h1, 3'd7, 0, 0, -1, 1'b0,
                 32'hA800_1000, pack7(32'h1, 32'h0, 32'hFFFF_FFFF, 32'h000F_FFFF, 32'h1, 32'h0, 32'h7),
                 7, 2'd0, 3'd0, 16 + VX);
    vecs[1] = mk(1'b0, 5'd0, 64'hA6000, 64'hA6000, 64'h1B801, 3'd3, 3, 3, -1, 1'b0,
                 32'hA800_0000, pack7(32'hA6000, 32'h0, 32'hA6000, 32'h0, 32'h1B801, 32'h0, 32'h3),
                 7, 2'd0, 3'd0, 0);
    vecs[2] = mk(1'b0, 5'd5, 64'h20, 64'h10, 64'h0, 3'd7, 0, 0, -1, 1'b0,
                 32'hA800_00A0, pack7(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0),
                 0, 2'd2, 3'd0, 2);
    vecs[3] = mk(1'b0, 5'd31, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEFF,
                 64'h8000_0000_0000_0000, 3'd5, 0, 0, 2, 1'b0,
                 32'hA800_03E0, pack7(32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEFF, 32'h1234_5678,
                                      32'h0, 32'h8000_0000, 32'h5),
                 3, 2'd1, 3'd2, 8);
    vecs[4] = mk(1'b1, 5'd17, 64'h0, 64'h0, 64'hFFFF_FFFF_0000_0000, 3'd0, 0, 0, -1, 1'b0,
                 32'hA800_1220, pack7(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0),
                 7, 2'd0, 3'd0, 16 + VX);
`ifdef RAB_SLICE_CFG_VERIFY_EN
    vecs[5] = mk(1'b1, 5'd1, 64'h100, 64'h1FF, 64'h40, 3'd7, 0, 0, -1, 1'b1,
                 32'hA800_1020, pack7(32'h100, 32'h0, 32'h1FF, 32'h0, 32'h40, 32'h0, 32'h7),
                 7, 2'd3, 3'd6, 18);
`endif

    rst = 1'b1; req_valid = 1'b0; req_port = 1'b0; req_idx = '0;
    req_first = '0; req_last = '0; req_base = '0; req_flags = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_aw_valid", cfg_req.aw_valid, 1'b0);
    chk("rst_w_valid", cfg_req.w_valid, 1'b0);
    chk("rst_b_ready", cfg_req.b_ready, 1'b0);
    chk("rst_ar_valid", cfg_req.ar_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_status", status, 2'd0);
    chk("rst_err_idx", err_idx, 3'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", req_ready, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("idle_no_done", done_cnt, 0);
    chk("idle_aw_valid", cfg_req.aw_valid, 1'b0);
    $display("reset/idle ready=%0d done_pulses=%0d", req_ready, done_cnt);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset while word 4 is waiting for an AW handshake.
    stall_aw = 20; stall_w_max = 0; err_at = -1; rd_bad = 1'b0;
    base_n = log_n; vec_base = log_n;
    req_valid = 1'b1; req_port = 1'b0; req_idx = 5'd2;
    req_first = 64'h1000; req_last = 64'h2000; req_base = 64'h3000; req_flags = 3'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int t = 0; t < 2000 && !((log_n - base_n) == 4 && cfg_req.aw_valid); t++) begin
      @(posedge clk); #1;
    end
    chk("rstmid_reach_word4", ((log_n - base_n) == 4) && cfg_req.aw_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstmid_aw_valid", cfg_req.aw_valid, 1'b0);
    chk("rstmid_w_valid", cfg_req.w_valid, 1'b0);
    chk("rstmid_b_ready", cfg_req.b_ready, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_no_flags_write", log_n - base_n, 4);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_ready_after", req_ready, 1'b1);
    $display("reset mid-sequence writes=%0d ready=%0d", log_n - base_n, req_ready);
    run_vec(NV, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
